// File: rtl/alu_reg_bank.sv
// alu_reg_bank: host-addressed operand/result/status registers with start command, busy tracking and irq for the ALU core
module alu_reg_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic [DATA_W-1:0] s_rdata,
    output logic              op_start,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [3:0]        op_code,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_lo,
    input  logic [DATA_W-1:0] res_hi,
    input  logic              res_ovf,
    output logic              irq
);
    localparam logic [ADDR_W-1:0] A_OPA    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_OPB    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_OPCODE = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_RES_LO = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_RES_HI = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_SCR0   = ADDR_W'(7);

    logic [DATA_W-1:0] res_lo_q, res_hi_q, rdata_n;
    logic [DATA_W-1:0] scratch [NUM_REGS-1:7];
    logic              busy, done, ovf, err, int_en;
    logic              wr, take, start_req, start_ok, set_err;
    logic [3:0]        clr;

    // Decode the bus access and the result strobe against the current busy state
    always_comb begin
        wr        = s_sel & s_wr;
        take      = res_valid & busy;
        start_req = wr && s_addr == A_CTRL && s_wdata[0];
        start_ok  = start_req & ~busy;
        set_err   = busy & (start_req | (wr && s_addr <= A_OPCODE));
        clr       = (wr && s_addr == A_STATUS) ? s_wdata[3:0] : 4'b0;
    end

    // Read mux; scratch covers every index from SCRATCH0 upward
    always_comb begin
        rdata_n = '0;
        case (s_addr)
            A_OPA:    rdata_n = op_a;
            A_OPB:    rdata_n = op_b;
            A_OPCODE: rdata_n = {{(DATA_W-4){1'b0}}, op_code};
            A_RES_LO: rdata_n = res_lo_q;
            A_RES_HI: rdata_n = res_hi_q;
            A_CTRL:   rdata_n = {{(DATA_W-2){1'b0}}, int_en, 1'b0};
            A_STATUS: rdata_n = {{(DATA_W-4){1'b0}}, err, ovf, busy, done};
            default:  rdata_n = scratch[s_addr];
        endcase
    end

    // Register state; flag sets override same-cycle W1C clears
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_rdata  <= '0;
            op_start <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_code  <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            err      <= 1'b0;
            int_en   <= 1'b0;
            irq      <= 1'b0;
            for (int i = 7; i < NUM_REGS; i++) scratch[i] <= '0;
        end else begin
            op_start <= start_ok;
            irq      <= int_en & (done | err);
            if (s_sel && !s_wr) s_rdata <= rdata_n;
            if (wr && !busy && s_addr == A_OPA) op_a <= s_wdata;
            if (wr && !busy && s_addr == A_OPB) op_b <= s_wdata;
            if (wr && !busy && s_addr == A_OPCODE) op_code <= s_wdata[3:0];
            if (wr && s_addr == A_CTRL) int_en <= s_wdata[1];
            if (wr && s_addr >= A_SCR0) scratch[s_addr] <= s_wdata;
            if (take) begin
                res_lo_q <= res_lo;
                res_hi_q <= res_hi;
            end
            busy <= take ? 1'b0 : (start_ok ? 1'b1 : busy);
            done <= take | (~start_ok & done & ~clr[0]);
            ovf  <= (take & res_ovf) | (ovf & ~clr[2]);
            err  <= set_err | (err & ~clr[3]);
        end
    end
endmodule

// File: doc/alu_reg_bank.md
Name: alu_reg_bank

Overview:
Parametrised register bank between the host bus and the ALU/multiplier core. It replaces the fixed 8x32 bank with an addressed bus interface, a self-clearing start command and busy tracking. It adds sticky W1C status, result capture on a valid strobe, an interrupt output and extra scratch registers. The host programs operands and opcode, then writes START. The core returns a two-word result. Software polls STATUS or takes irq.

Parameters:
DATA_W, 32, register and bus data width (>=8)
NUM_REGS, 16, register count; power of 2, >=8
ADDR_W, 4, bus address width; must equal log2(NUM_REGS)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
s_sel  in  1  bus access strobe, one access per cycle
s_wr  in  1  1=write, 0=read (qualified by s_sel)
s_addr  in  ADDR_W  register index
s_wdata  in  DATA_W  write data
s_rdata  out  DATA_W  read data, registered
op_start  out  1  one-cycle start pulse to core
op_a  out  DATA_W  OPA register contents
op_b  out  DATA_W  OPB register contents
op_code  out  4  OPCODE[3:0]
res_valid  in  1  core result strobe, one cycle
res_lo  in  DATA_W  result low word
res_hi  in  DATA_W  result high word (multiplier upper half)
res_ovf  in  1  overflow flag, qualified by res_valid
irq  out  1  interrupt, level

Behaviour:
- Reset (async assert, sync release): every register, s_rdata, op_start, irq and busy = 0.
- Map: 0 OPA rw; 1 OPB rw; 2 OPCODE rw (bits [3:0], others read 0); 3 RES_LO ro; 4 RES_HI ro; 5 CTRL; 6 STATUS; 7 SCRATCH0 rw; 8..NUM_REGS-1 scratch rw.
- CTRL: bit0 START, write-1 action, reads 0. bit1 INT_EN rw. Other bits read 0.
- STATUS: bit0 DONE (sticky, W1C), bit1 BUSY (ro), bit2 OVF (sticky, W1C), bit3 ERR (sticky, W1C). Other bits read 0.
- Writes take effect at the clock edge where s_sel=1 and s_wr=1. Writes to ro addresses are ignored.
- Read: s_sel=1, s_wr=0 in cycle N; s_rdata is valid in cycle N+1 and holds until the next read. Read has no side effects.
- START write with busy=0: op_start=1 in cycle N+1 only. busy=1 from N+1. DONE is cleared at the same edge.
- START write with busy=1: ignored, no pulse, ERR set.
- Writes to OPA/OPB/OPCODE while busy=1 are ignored and set ERR. Scratch and CTRL.INT_EN stay writable.
- res_valid=1 with busy=1: RES_LO<=res_lo, RES_HI<=res_hi, busy<=0, DONE<=1, OVF<=OVF|res_ovf.
- res_valid=1 with busy=0: ignored entirely, no register changes.
- Same-cycle conflicts:
  - res_valid and a W1C write of DONE/OVF: set wins.
  - res_valid and a START write: the result completes the current op; START sees busy=1, is ignored and sets ERR.
- irq = INT_EN & (DONE | ERR), registered, i.e. it follows the flags one cycle later. It deasserts one cycle after the flags are cleared.
- The core may return res_valid as early as the cycle after op_start. No timeout exists; busy persists until res_valid or reset.
- Reset mid-operation clears busy. A later res_valid is ignored.
- NUM_REGS >= 8 keeps every index in range. s_addr is fully decoded; no aliasing.

Test Plan:
- Reset then read all 16 addresses -> s_rdata=0 each, one cycle after each read; irq=0, op_start=0.
- Write OPA=0x0000_0007, OPB=0x0000_0006, OPCODE=0x3, CTRL=0x3 -> op_start high exactly one cycle; STATUS reads 0x2. Core returns res_lo=0x2A, res_hi=0, res_valid -> STATUS=0x1, RES_LO=0x2A, irq=1 next cycle.
- Busy, write OPA=0xFFFF_FFFF and CTRL=0x1 -> OPA unchanged, no second op_start, STATUS=0x A (ERR|BUSY); write STATUS=0x8 -> ERR clears.
- Same-cycle res_valid with res_ovf=1 and STATUS W1C write 0x5 -> DONE=1, OVF=1 afterwards.
- res_valid with busy=0, res_lo=0x1234 -> RES_LO unchanged, STATUS unchanged.
- Start an op, assert reset_n=0 mid-op, release, then pulse res_valid -> all registers 0, STATUS=0, irq=0.
